// File: rtl/hook_pkg.sv
// Shared types and constants for the hook rope controller.
// Holds the FSM state enum, angle/screen limits and coordinate clamp.
package hook_pkg;

  typedef enum logic [1:0] {
    SWING,
    EXTEND,
    RETRACT
  } hook_state_t;

  localparam int ANG_MAX    = 32;
  localparam int ANG_CENTER = 16;
  localparam int SCREEN_W   = 640;
  localparam int SCREEN_H   = 480;
  localparam int Q_FRAC     = 8;

  function automatic logic [10:0] clamp_coord(
    input logic signed [12:0] v,
    input int                 hi
  );
    logic signed [12:0] top;
    top = 13'(hi);
    if (v < 13'sd0) return 11'd0;
    if (v > top) return 11'(top);
    return 11'(v);
  endfunction

endpackage

// File: rtl/hook_rope_controller_if.sv
// Frame, key, collision inputs and line-drawing outputs of the rope.
// master drives the inputs and reads the line; slave is the controller.
interface hook_rope_controller_if;

  logic        startOfFrame;
  logic        fireKey;
  logic        hookCollision;
  logic        borderCollision;
  logic [2:0]  objectWeight;
  logic [10:0] x1;
  logic [10:0] y1;
  logic [10:0] x2;
  logic [10:0] y2;
  logic [4:0]  width;
  logic [7:0]  lineColor;
  logic [1:0]  hookState;
  logic        delivered;

  modport master (
    output startOfFrame, fireKey,
    output hookCollision, borderCollision,
    output objectWeight,
    input  x1, y1, x2, y2,
    input  width, lineColor,
    input  hookState, delivered
  );

  modport slave (
    input  startOfFrame, fireKey,
    input  hookCollision, borderCollision,
    input  objectWeight,
    output x1, y1, x2, y2,
    output width, lineColor,
    output hookState, delivered
  );

endinterface

// File: rtl/hook_trig_lut.sv
// Angle index to Q1.8 sin/cos ROM, 5 degree steps over +-80 degrees.
// Ports: ang (0..32) in; sin_q, cos_q signed 10b out.
module hook_trig_lut
  import hook_pkg::*;
(
  input  logic [5:0]        ang,
  output logic signed [9:0] sin_q,
  output logic signed [9:0] cos_q
);

  logic [5:0]        k;
  logic signed [9:0] s_mag;
  logic signed [9:0] c_mag;

  // Fold onto |angle|: cos is even, sin is odd.
  always_comb begin
    if (ang >= 6'(ANG_CENTER)) k = ang - 6'(ANG_CENTER);
    else k = 6'(ANG_CENTER) - ang;
    case (k)
      6'd0:  {s_mag, c_mag} = {10'sd0,   10'sd256};
      6'd1:  {s_mag, c_mag} = {10'sd22,  10'sd255};
      6'd2:  {s_mag, c_mag} = {10'sd44,  10'sd252};
      6'd3:  {s_mag, c_mag} = {10'sd66,  10'sd247};
      6'd4:  {s_mag, c_mag} = {10'sd88,  10'sd241};
      6'd5:  {s_mag, c_mag} = {10'sd108, 10'sd232};
      6'd6:  {s_mag, c_mag} = {10'sd128, 10'sd222};
      6'd7:  {s_mag, c_mag} = {10'sd147, 10'sd210};
      6'd8:  {s_mag, c_mag} = {10'sd165, 10'sd196};
      6'd9:  {s_mag, c_mag} = {10'sd181, 10'sd181};
      6'd10: {s_mag, c_mag} = {10'sd196, 10'sd165};
      6'd11: {s_mag, c_mag} = {10'sd210, 10'sd147};
      6'd12: {s_mag, c_mag} = {10'sd222, 10'sd128};
      6'd13: {s_mag, c_mag} = {10'sd232, 10'sd108};
      6'd14: {s_mag, c_mag} = {10'sd241, 10'sd88};
      6'd15: {s_mag, c_mag} = {10'sd247, 10'sd66};
      6'd16: {s_mag, c_mag} = {10'sd252, 10'sd44};
      default: {s_mag, c_mag} = {10'sd0, 10'sd256};
    endcase
    sin_q = (ang < 6'(ANG_CENTER)) ? -s_mag : s_mag;
    cos_q = c_mag;
  end

endmodule

// File: rtl/hook_rope_controller.sv
// Rope swing/extend/retract FSM with per-frame endpoint computation.
// Ports: clk, resetN (async low), bus (slave side of the rope interface).
module hook_rope_controller
  import hook_pkg::*;
#(
  parameter int         PIVOT_X       = 320,
  parameter int         PIVOT_Y       = 40,
  parameter int         MIN_LEN       = 32,
  parameter int         MAX_LEN       = 400,
  parameter int         EXTEND_SPEED  = 4,
  parameter int         RETRACT_SPEED = 6,
  parameter int         ROPE_WIDTH    = 2,
  parameter logic [7:0] ROPE_COLOR    = 8'h92
) (
  input logic clk,
  input logic resetN,
  hook_rope_controller_if.slave bus
);

  hook_state_t state;
  logic [5:0]  ang;
  logic        dir_dn;
  logic [9:0]  len;
  logic        loaded;
  logic [2:0]  wt;
  logic        hit_f;
  logic        bord_f;
  logic [2:0]  hit_wt;
  logic        fire_q;
  logic        fire_ok;
  logic        del_q;
  logic [10:0] x2_q;
  logic [10:0] y2_q;

  logic [5:0]         ang_nx;
  logic               fire_edge;
  logic [9:0]         up_len;
  logic [9:0]         dn_len;
  logic [9:0]         speed;
  logic signed [9:0]  sin_q;
  logic signed [9:0]  cos_q;
  logic signed [20:0] px;
  logic signed [20:0] py;
  logic signed [12:0] sx;
  logic signed [12:0] sy;

  hook_trig_lut u_lut (
    .ang   (ang),
    .sin_q (sin_q),
    .cos_q (cos_q)
  );

  always_comb begin
    ang_nx = dir_dn ? ang - 6'd1 : ang + 6'd1;
    // fire_ok: a key held through reset must be released first.
    fire_edge = bus.fireKey & ~fire_q & fire_ok;
    if (len >= 10'(MAX_LEN - EXTEND_SPEED))
      up_len = 10'(MAX_LEN);
    else
      up_len = len + 10'(EXTEND_SPEED);
    if (!loaded)
      speed = 10'(RETRACT_SPEED);
    else if ({7'd0, wt} >= 10'(RETRACT_SPEED))
      speed = 10'd1;
    else
      speed = 10'(RETRACT_SPEED) - {7'd0, wt};
    if (len <= 10'(MIN_LEN) + speed)
      dn_len = 10'(MIN_LEN);
    else
      dn_len = len - speed;
    px = $signed({11'd0, len}) * 21'(sin_q);
    py = $signed({11'd0, len}) * 21'(cos_q);
    sx = 13'(PIVOT_X) + 13'(px >>> Q_FRAC);
    sy = 13'(PIVOT_Y) + 13'(py >>> Q_FRAC);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state   <= SWING;
      ang     <= 6'(ANG_CENTER);
      dir_dn  <= 1'b0;
      len     <= 10'(MIN_LEN);
      loaded  <= 1'b0;
      wt      <= 3'd0;
      hit_f   <= 1'b0;
      bord_f  <= 1'b0;
      hit_wt  <= 3'd0;
      fire_q  <= 1'b0;
      fire_ok <= 1'b0;
      del_q   <= 1'b0;
      x2_q    <= 11'(PIVOT_X);
      y2_q    <= 11'(PIVOT_Y + MIN_LEN);
    end else begin
      del_q <= 1'b0;
      x2_q  <= clamp_coord(sx, SCREEN_W - 1);
      y2_q  <= clamp_coord(sy, SCREEN_H - 1);
      if (bus.hookCollision && (!hit_f || bus.startOfFrame))
        hit_wt <= bus.objectWeight;
      if (bus.hookCollision) hit_f <= 1'b1;
      if (bus.borderCollision) bord_f <= 1'b1;
      if (bus.startOfFrame) begin
        // Flags were just evaluated; restart them from this cycle.
        hit_f   <= bus.hookCollision;
        bord_f  <= bus.borderCollision;
        fire_q  <= bus.fireKey;
        fire_ok <= 1'b1;
        unique case (state)
          SWING: begin
            len <= 10'(MIN_LEN);
            if (fire_edge) begin
              state <= EXTEND;
            end else begin
              ang <= ang_nx;
              if (ang_nx == 6'(ANG_MAX)) dir_dn <= 1'b1;
              else if (ang_nx == 6'd0) dir_dn <= 1'b0;
            end
          end
          EXTEND: begin
            if (hit_f) begin
              state  <= RETRACT;
              loaded <= 1'b1;
              wt     <= hit_wt;
            end else if (bord_f || len >= 10'(MAX_LEN)) begin
              state  <= RETRACT;
              loaded <= 1'b0;
            end else begin
              len <= up_len;
            end
          end
          RETRACT: begin
            len <= dn_len;
            if (dn_len == 10'(MIN_LEN)) begin
              state  <= SWING;
              del_q  <= loaded;
              loaded <= 1'b0;
            end
          end
          default: state <= SWING;
        endcase
      end
    end
  end

  assign bus.x1        = 11'(PIVOT_X);
  assign bus.y1        = 11'(PIVOT_Y);
  assign bus.x2        = x2_q;
  assign bus.y2        = y2_q;
  assign bus.width     = 5'(ROPE_WIDTH);
  assign bus.lineColor = ROPE_COLOR;
  assign bus.hookState = state;
  assign bus.delivered = del_q;

endmodule
